hdmi_pixel_packer: RTL and testbench

//  Converts the captured HDMI pixel stream (hs/vs/de + 24b RGB) into wide, packed

---
 rtl/hdmi_pkg.sv | 19 +
 rtl/hdmi_lane_packer.sv | 55 +++++
 rtl/hdmi_pixel_packer.sv | 145 ++++++++++++++
 tb/tb_hdmi_pixel_packer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI pixel packer: pixel formats, FSM encoding and
// the RGB888 to RGB565 reduction.
package hdmi_pkg;

   localparam int unsigned PIX_MODE_XRGB = 0;
   localparam int unsigned PIX_MODE_565  = 1;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Keep the top bits of each channel: {R[7:3], G[7:2], B[7:3]}
   function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

endpackage

// File: rtl/hdmi_lane_packer.sv
// Collects PIX_W-bit pixels into an OUT_W-bit word, first pixel in lane 0.
// word_c/done_c/flush_c describe the word completed in the current cycle.
module hdmi_lane_packer #(
   parameter int unsigned OUT_W = 64,
   parameter int unsigned PIX_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             de,
   input  logic             clear,
   input  logic [PIX_W-1:0] pix,
   output logic [OUT_W-1:0] word_c,
   output logic             done_c,
   output logic             flush_c
);

   localparam int unsigned PPW    = OUT_W / PIX_W;
   localparam int unsigned LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

   logic [OUT_W-1:0]  lanes;
   logic [LANE_W-1:0] lane_cnt;

   // A frame edge discards the partial word and suppresses any completion
   assign done_c  = en & de & ~clear & (lane_cnt == LANE_W'(PPW - 1));
   assign flush_c = en & ~de & ~clear & (lane_cnt != '0);

   always_comb begin
      word_c = lanes;
      for (int unsigned i = 0; i < PPW; i++) begin
         if (de && lane_cnt == LANE_W'(i)) begin
            word_c[i*PIX_W +: PIX_W] = pix;
         end
      end
   end

   // Lanes return to zero after every word so a flushed word has empty upper lanes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes    <= '0;
         lane_cnt <= '0;
      end else if (clear || done_c || flush_c) begin
         lanes    <= '0;
         lane_cnt <= '0;
      end else if (en && de) begin
         for (int unsigned i = 0; i < PPW; i++) begin
            if (lane_cnt == LANE_W'(i)) begin
               lanes[i*PIX_W +: PIX_W] <= pix;
            end
         end
         lane_cnt <= lane_cnt + LANE_W'(1);
      end
   end

endmodule

// File: rtl/hdmi_pixel_packer.sv
// HDMI capture front end: waits out power-up and sync frames, packs pixels into
// frame-buffer write words and tracks drops and read start.
module hdmi_pixel_packer
   import hdmi_pkg::*;
#(
   parameter int unsigned OUT_W           = 64,
   parameter int unsigned PIX_MODE        = 0,
   parameter int unsigned PIC_WAIT        = 10,
   parameter int unsigned SYNC_FRAMES     = 1,
   parameter int unsigned RD_START_FRAMES = 2,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             hdmi_clk,
   input  logic             sys_rst,
   input  logic             hdmi_hs_in,
   input  logic             hdmi_vs_in,
   input  logic             hdmi_de_in,
   input  logic [23:0]      hdmi_data_in,
   input  logic             fifo_full,
   output logic             hdmi_wr_en,
   output logic [OUT_W-1:0] hdmi_data_out,
   output logic             frame_start,
   output logic             pic_valid,
   output logic             read_enable,
   output logic             frame_err,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int unsigned PIX_W  = (PIX_MODE == PIX_MODE_565) ? 16 : 32;
   localparam int unsigned WAIT_W = $clog2(PIC_WAIT + 2);
   localparam int unsigned SYNC_W = $clog2(SYNC_FRAMES + 2);
   localparam int unsigned FRM_W  = $clog2(RD_START_FRAMES + 2);

   state_t            state;
   logic              vs_d1;
   logic              capturing;
   logic [WAIT_W-1:0] cyc_cnt;
   logic [SYNC_W-1:0] sync_cnt;
   logic [FRM_W-1:0]  frm_cnt;
   logic              vs_rise;
   logic [PIX_W-1:0]  pix;
   logic [OUT_W-1:0]  word;
   logic              done;
   logic              flush;
   logic              write;
   logic              drop;
   logic              unused_hs;

   assign unused_hs = hdmi_hs_in;
   assign vs_rise   = hdmi_vs_in & ~vs_d1;
   assign write     = done | flush;
   assign drop      = write & fifo_full;

   if (PIX_MODE == PIX_MODE_XRGB) begin : g_xrgb
      assign pix = PIX_W'({8'h00, hdmi_data_in});
   end else begin : g_565
      assign pix = PIX_W'(rgb888_to_565(hdmi_data_in));
   end

   hdmi_lane_packer #(
      .OUT_W (OUT_W),
      .PIX_W (PIX_W)
   ) u_lane_packer (
      .clk     (hdmi_clk),
      .rst     (sys_rst),
      .en      (capturing),
      .de      (hdmi_de_in),
      .clear   (vs_rise),
      .pix     (pix),
      .word_c  (word),
      .done_c  (done),
      .flush_c (flush)
   );

   always_ff @(posedge hdmi_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state         <= ST_WAIT;
         vs_d1         <= 1'b0;
         capturing     <= 1'b0;
         cyc_cnt       <= '0;
         sync_cnt      <= '0;
         frm_cnt       <= '0;
         hdmi_wr_en    <= 1'b0;
         hdmi_data_out <= '0;
         frame_start   <= 1'b0;
         pic_valid     <= 1'b0;
         read_enable   <= 1'b0;
         frame_err     <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         vs_d1       <= hdmi_vs_in;
         frame_start <= 1'b0;
         hdmi_wr_en  <= write & ~fifo_full;
         if (write && !fifo_full) begin
            hdmi_data_out <= word;
         end

         // A drop in the frame_start cycle keeps the error flag set
         if (drop) begin
            frame_err <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + CNT_W'(1);
            end
         end else if (frame_start) begin
            frame_err <= 1'b0;
         end

         if (state != ST_WAIT && vs_rise && frm_cnt != FRM_W'(RD_START_FRAMES)) begin
            frm_cnt <= frm_cnt + FRM_W'(1);
         end
         if (frm_cnt == FRM_W'(RD_START_FRAMES)) begin
            read_enable <= 1'b1;
         end

         case (state)
            ST_WAIT: begin
               if (cyc_cnt == WAIT_W'(PIC_WAIT)) begin
                  state <= ST_SYNC;
               end else begin
                  cyc_cnt <= cyc_cnt + WAIT_W'(1);
               end
            end
            ST_SYNC: begin
               if (vs_rise) begin
                  if (sync_cnt == SYNC_W'(SYNC_FRAMES - 1)) begin
                     state     <= ST_RUN;
                     pic_valid <= 1'b1;
                  end else begin
                     sync_cnt <= sync_cnt + SYNC_W'(1);
                  end
               end
            end
            ST_RUN: begin
               // The edge that entered RUN does not start capture; the next one does
               if (vs_rise) begin
                  capturing   <= 1'b1;
                  frame_start <= 1'b1;
               end
            end
            default: state <= ST_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Bench for hdmi_pixel_packer: an XRGB8888 and an RGB565 instance share sync and
// reset; written words are checked against scoreboard queues filled at drive time.
module tb_hdmi_pixel_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        hs;
   logic        vs;
   logic        de;
   logic        de2;
   logic [23:0] data;
   logic        full;

   logic        wr_en, fs, pv, re, ferr;
   logic [63:0] dout;
   logic [15:0] dcnt;
   logic        wr_en2, fs2, pv2, re2, ferr2;
   logic [63:0] dout2;
   logic [15:0] dcnt2;

   logic [63:0] q64[$];
   logic [63:0] q565[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   hdmi_pixel_packer #(.OUT_W(64), .PIX_MODE(0)) u_dut (
      .hdmi_clk      (clk),
      .sys_rst       (rst),
      .hdmi_hs_in    (hs),
      .hdmi_vs_in    (vs),
      .hdmi_de_in    (de),
      .hdmi_data_in  (data),
      .fifo_full     (full),
      .hdmi_wr_en    (wr_en),
      .hdmi_data_out (dout),
      .frame_start   (fs),
      .pic_valid     (pv),
      .read_enable   (re),
      .frame_err     (ferr),
      .drop_cnt      (dcnt)
   );

   hdmi_pixel_packer #(.OUT_W(64), .PIX_MODE(1)) u_dut565 (
      .hdmi_clk      (clk),
      .sys_rst       (rst),
      .hdmi_hs_in    (hs),
      .hdmi_vs_in    (vs),
      .hdmi_de_in    (de2),
      .hdmi_data_in  (data),
      .fifo_full     (full),
      .hdmi_wr_en    (wr_en2),
      .hdmi_data_out (dout2),
      .frame_start   (fs2),
      .pic_valid     (pv2),
      .read_enable   (re2),
      .frame_err     (ferr2),
      .drop_cnt      (dcnt2)
   );

   // Scoreboard: every write strobe pops the oldest expected word
   always @(negedge clk) begin
      logic [63:0] exp;
      if (!rst && wr_en) begin
         n_checks++;
         if (q64.size() == 0) begin
            n_fail++;
            $display("FAIL xrgb_word: got write %h, required no write", dout);
         end else begin
            exp = q64.pop_front();
            if (dout !== exp) begin
               n_fail++;
               $display("FAIL xrgb_word: got %h, required %h", dout, exp);
            end
         end
      end
      if (!rst && wr_en2) begin
         n_checks++;
         if (q565.size() == 0) begin
            n_fail++;
            $display("FAIL rgb565_word: got write %h, required no write", dout2);
         end else begin
            exp = q565.pop_front();
            if (dout2 !== exp) begin
               n_fail++;
               $display("FAIL rgb565_word: got %h, required %h", dout2, exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; de2 = 1'b0; data = '0; full = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({wr_en, fs, pv, re, ferr} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, required 00000", {wr_en, fs, pv, re, ferr});
      end
      n_checks++;
      if (dout !== 64'h0 || dcnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: got dout=%h drop=%0d, required 0/0", dout, dcnt);
      end
   endtask

   task automatic test_sync_start();
      rst = 1'b0;
      repeat (4) tick();
      vs = 1'b1;                       // sampled at cycle 5, still in WAIT
      repeat (4) tick();
      vs = 1'b0;
      repeat (22) tick();
      n_checks++;
      if (pv !== 1'b0) begin
         n_fail++;
         $display("FAIL early_edge_ignored: got pic_valid=%b, required 0", pv);
      end
      repeat (9) tick();
      vs = 1'b1;                       // sampled at cycle 40
      tick();
      n_checks++;
      if (pv !== 1'b1 || fs !== 1'b0) begin
         n_fail++;
         $display("FAIL run_entry: got pic_valid=%b frame_start=%b, required 1/0", pv, fs);
      end
      tick();
      n_checks++;
      if (fs !== 1'b0) begin
         n_fail++;
         $display("FAIL no_start_on_entry: got frame_start=%b, required 0", fs);
      end
      repeat (3) tick();
      vs = 1'b0;
      n_checks++;
      if (re !== 1'b0) begin
         n_fail++;
         $display("FAIL read_enable_early: got %b, required 0", re);
      end
      repeat (35) tick();
      vs = 1'b1;                       // sampled at cycle 80
      tick();
      n_checks++;
      if (fs !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_start_pulse: got %b, required 1", fs);
      end
      tick();
      n_checks++;
      if (fs !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_start_width: got %b, required 0", fs);
      end
      tick();
      n_checks++;
      if (re !== 1'b1 || re2 !== 1'b1) begin
         n_fail++;
         $display("FAIL read_enable_set: got %b/%b, required 1/1", re, re2);
      end
      vs = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_xrgb_pack();
      logic [23:0] line1 [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
      logic [23:0] line2 [3] = '{24'hAABBCC, 24'h123456, 24'h0F0F0F};
      q64.push_back(64'h00222222_00111111);
      q64.push_back(64'h00444444_00333333);
      for (int i = 0; i < 4; i++) begin
         de = 1'b1; data = line1[i];
         tick();
      end
      de = 1'b0;
      repeat (4) tick();
      q64.push_back(64'h00123456_00AABBCC);
      q64.push_back(64'h00000000_000F0F0F);
      for (int i = 0; i < 3; i++) begin
         de = 1'b1; data = line2[i];
         tick();
      end
      de = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (q64.size() != 0) begin
         n_fail++;
         $display("FAIL xrgb_words_seen: got %0d pending, required 0", q64.size());
      end
      n_checks++;
      if (dout !== 64'h00000000_000F0F0F || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL xrgb_hold: got %h wr=%b, required 000000000f0f0f/0", dout, wr_en);
      end
   endtask

   task automatic test_565_flush();
      q565.push_back(64'hFFFFFFFF_FFFFFFFF);
      q565.push_back(64'h00000000_0000FFFF);
      for (int i = 0; i < 5; i++) begin
         de2 = 1'b1; data = 24'hFFFFFF;
         tick();
      end
      de2 = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (q565.size() != 0) begin
         n_fail++;
         $display("FAIL rgb565_words_seen: got %0d pending, required 0", q565.size());
      end
   endtask

   task automatic test_fifo_full();
      full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         de = 1'b1; data = 24'(i + 1);
         tick();
      end
      de = 1'b0;
      tick();
      full = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (dcnt !== 16'd3 || ferr !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_count: got drop=%0d err=%b, required 3/1", dcnt, ferr);
      end
      vs = 1'b1;
      tick();
      n_checks++;
      if (fs !== 1'b1 || ferr !== 1'b1) begin
         n_fail++;
         $display("FAIL err_until_start: got fs=%b err=%b, required 1/1", fs, ferr);
      end
      tick();
      n_checks++;
      if (ferr !== 1'b0 || dcnt !== 16'd3) begin
         n_fail++;
         $display("FAIL err_cleared: got err=%b drop=%0d, required 0/3", ferr, dcnt);
      end
      vs = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_vs_discard();
      logic [23:0] line1 [3] = '{24'h010203, 24'h040506, 24'h070809};
      logic [23:0] line2 [4] = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF};
      q64.push_back(64'h00040506_00010203);
      for (int i = 0; i < 3; i++) begin
         de = 1'b1; de2 = 1'b1; data = line1[i];
         tick();
      end
      de = 1'b0; de2 = 1'b0; vs = 1'b1;  // frame edge on the flush cycle
      repeat (3) tick();
      vs = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (q64.size() != 0 || q565.size() != 0) begin
         n_fail++;
         $display("FAIL partial_discard: got %0d/%0d pending, required 0/0", q64.size(), q565.size());
      end
      q64.push_back(64'h0000FF00_000000FF);
      q64.push_back(64'h00FFFFFF_00FF0000);
      q565.push_back(64'hFFFF_F800_07E0_001F);
      for (int i = 0; i < 4; i++) begin
         de = 1'b1; de2 = 1'b1; data = line2[i];
         tick();
      end
      de = 1'b0; de2 = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (q64.size() != 0 || q565.size() != 0) begin
         n_fail++;
         $display("FAIL lane0_restart: got %0d/%0d pending, required 0/0", q64.size(), q565.size());
      end
   endtask

   task automatic test_mid_reset();
      de = 1'b1; de2 = 1'b1; data = 24'h777777;
      tick();
      #1;
      rst = 1'b1; de = 1'b0; de2 = 1'b0;
      #1;
      n_checks++;
      if ({wr_en, fs, pv, re, ferr} !== 5'b0 || {pv2, re2} !== 2'b0) begin
         n_fail++;
         $display("FAIL async_reset_flags: got %b %b, required 00000 00",
                  {wr_en, fs, pv, re, ferr}, {pv2, re2});
      end
      n_checks++;
      if (dout !== 64'h0 || dcnt !== 16'h0 || dout2 !== 64'h0) begin
         n_fail++;
         $display("FAIL async_reset_data: got %h %0d %h, required 0", dout, dcnt, dout2);
      end
      tick();
      rst = 1'b0;
      repeat (14) tick();
      n_checks++;
      if (pv !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_wait: got pic_valid=%b, required 0", pv);
      end
      vs = 1'b1;
      tick();
      n_checks++;
      if (pv !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_run: got pic_valid=%b, required 1", pv);
      end
      vs = 1'b0;
      repeat (3) tick();
      vs = 1'b1;
      tick();
      n_checks++;
      if (fs !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_frame_start: got %b, required 1", fs);
      end
      vs = 1'b0;
      repeat (2) tick();
      q64.push_back(64'h00010101_00ABCDEF);
      de = 1'b1; data = 24'hABCDEF;
      tick();
      data = 24'h010101;
      tick();
      de = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (q64.size() != 0 || re !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_capture: got %0d pending re=%b, required 0/1", q64.size(), re);
      end
   endtask

   initial begin
      test_reset();
      test_sync_start();
      test_xrgb_pack();
      test_565_flush();
      test_fifo_full();
      test_vs_discard();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000ns");
      $fatal(1);
   end

endmodule
